// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and small helpers for the pipeline hazard/forwarding controller.
package hazard_ctrl_pkg;

  // Forwarding-mux select encodings (E-stage selects zero-extend these to 3 bits).
  localparam logic [1:0] SEL_RF = 2'd0;
  localparam logic [1:0] SEL_W  = 2'd1;
  localparam logic [1:0] SEL_M  = 2'd2;

  // Tuse value meaning "operand not read by this instruction".
  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2,
    MD_HILO = 2'd3
  } md_op_t;

  // Destination tag carried down the pipeline.
  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
  } tag_t;

  // Tnew counts down by one per stage and never goes negative.
  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // $zero is hard-wired, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] dst);
    return (r != 5'd0) && (r == dst);
  endfunction

  // An operand must wait if a producer in E or M will not have its result
  // ready by the time this instruction needs it.
  function automatic logic use_stall(input logic [4:0] r, input logic [1:0] tuse,
                                     input tag_t e, input tag_t m);
    return (tuse != TUSE_NONE) &&
           ((reg_match(r, e.dst) && (e.tnew > tuse)) ||
            (reg_match(r, m.dst) && (m.tnew > tuse)));
  endfunction

  // Youngest ready producer wins: M (only once its value exists), then W.
  function automatic logic [1:0] fwd_sel(input logic [4:0] r, input tag_t m,
                                         input logic [4:0] dst_w);
    if (reg_match(r, m.dst) && (m.tnew == 2'd0)) return SEL_M;
    if (reg_match(r, dst_w))                      return SEL_W;
    return SEL_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// Multiply/divide unit busy tracker: loads a cycle count when an MDU start
// sits in E and counts it down; busy covers both the start cycle and the count.
module md_busy_cnt
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic   clk,
  input  logic   reset,
  input  md_op_t md_op_e,
  output logic   md_busy
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [3:0] md_cnt;
  logic       md_start;

  assign md_start = (md_op_e == MD_MULT) || (md_op_e == MD_DIV);

  // Count register: a fresh start reloads, taking precedence over the decrement.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt <= 4'd0;
    end else if (md_start) begin
      md_cnt <= (md_op_e == MD_MULT) ? MULT_LOAD : DIV_LOAD;
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

  assign md_busy = (md_cnt != 4'd0) || md_start;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage MIPS pipeline: shadows the
// destination tags of E/M/W, produces forwarding selects and the D-stage stall.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] tuse_rs_d,
  input  logic [1:0] tuse_rt_d,
  input  logic [4:0] dst_d,
  input  logic [1:0] tnew_d,
  input  logic [1:0] md_op_d,
  output logic       stall,
  output logic [1:0] frs_d,
  output logic [1:0] frt_d,
  output logic [2:0] frs_e,
  output logic [2:0] frt_e,
  output logic       frt_m,
  output logic       md_busy
);

  // Only fields that some output depends on are shadowed: rs past E, rt past M
  // and Tnew in W are never consulted.
  logic [4:0] rs_e;
  logic [4:0] rt_e;
  tag_t       tag_e;
  md_op_t     md_op_e;
  logic [4:0] rt_m;
  tag_t       tag_m;
  logic [4:0] dst_w;

  logic       mdu_stall;

  // Tag pipeline: D->E is bubbled on stall; E->M->W always advances.
  // NOTE: every pipeline tag is cleared by the asynchronous reset so that all
  // outputs fall to 0 immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_e    <= 5'd0;
      rt_e    <= 5'd0;
      tag_e   <= '0;
      md_op_e <= MD_NONE;
      rt_m    <= 5'd0;
      tag_m   <= '0;
      dst_w   <= 5'd0;
    end else begin
      if (stall) begin
        rs_e    <= 5'd0;
        rt_e    <= 5'd0;
        tag_e   <= '0;
        md_op_e <= MD_NONE;
      end else begin
        rs_e    <= rs_d;
        rt_e    <= rt_d;
        tag_e   <= '{dst: dst_d, tnew: tnew_d};
        md_op_e <= md_op_t'(md_op_d);
      end
      rt_m  <= rt_e;
      tag_m <= '{dst: tag_e.dst, tnew: tnew_dec(tag_e.tnew)};
      dst_w <= tag_m.dst;
    end
  end

  md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_cnt (
    .clk     (clk),
    .reset   (reset),
    .md_op_e (md_op_e),
    .md_busy (md_busy)
  );

  // Any MDU-touching instruction waits in D while the unit is busy.
  assign mdu_stall = (md_op_t'(md_op_d) != MD_NONE) && md_busy;

  assign stall = use_stall(rs_d, tuse_rs_d, tag_e, tag_m) ||
                 use_stall(rt_d, tuse_rt_d, tag_e, tag_m) ||
                 mdu_stall;

  assign frs_d = fwd_sel(rs_d, tag_m, dst_w);
  assign frt_d = fwd_sel(rt_d, tag_m, dst_w);
  assign frs_e = {1'b0, fwd_sel(rs_e, tag_m, dst_w)};
  assign frt_e = {1'b0, fwd_sel(rt_e, tag_m, dst_w)};
  assign frt_m = reg_match(rt_m, dst_w);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a per-cycle table of D-stage instructions
// with hand-computed outputs, then divide-latency and async-reset sequences.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, dst_d;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d, md_op_d;
  logic       stall, frt_m, md_busy;
  logic [1:0] frs_d, frt_d;
  logic [2:0] frs_e, frt_e;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .rs_d      (rs_d),
    .rt_d      (rt_d),
    .tuse_rs_d (tuse_rs_d),
    .tuse_rt_d (tuse_rt_d),
    .dst_d     (dst_d),
    .tnew_d    (tnew_d),
    .md_op_d   (md_op_d),
    .stall     (stall),
    .frs_d     (frs_d),
    .frt_d     (frt_d),
    .frs_e     (frs_e),
    .frt_e     (frt_e),
    .frt_m     (frt_m),
    .md_busy   (md_busy)
  );

  // Expected outputs packed as {stall, frs_d, frt_d, frs_e, frt_e, frt_m, md_busy}.
  typedef struct {
    logic [4:0]  rs, rt;
    logic [1:0]  trs, trt;
    logic [4:0]  dst;
    logic [1:0]  tnew, md;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input int rs, rt, trs, trt, dst, tnew, md,
                             input int st, fsd, ftd, fse, fte, ftm, bsy);
    vec_t r;
    r.rs = 5'(rs); r.rt = 5'(rt); r.trs = 2'(trs); r.trt = 2'(trt);
    r.dst = 5'(dst); r.tnew = 2'(tnew); r.md = 2'(md);
    r.exp = {1'(st), 2'(fsd), 2'(ftd), 3'(fse), 3'(fte), 1'(ftm), 1'(bsy)};
    return r;
  endfunction

  function automatic logic [12:0] outs();
    return {stall, frs_d, frt_d, frs_e, frt_e, frt_m, md_busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, rt, input logic [1:0] trs, trt,
                       input logic [4:0] dst, input logic [1:0] tnew, md);
    rs_d = rs; rt_d = rt; tuse_rs_d = trs; tuse_rt_d = trt;
    dst_d = dst; tnew_d = tnew; md_op_d = md;
  endtask

  task automatic drive_nop();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 2'd0);
  endtask

  initial begin
    int busy_n;
    int guard;

    // Load-use: lw r2, then addu reading r2 stalls once, then W-forward in E.
    vecs.push_back(v( 1, 3, 1, 3, 2, 2, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 2, 6, 1, 1, 7, 1, 0,  1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 2, 6, 1, 1, 7, 1, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    // ALU-ALU: no stall, M-forward in E next cycle.
    vecs.push_back(v( 1, 1, 1, 1, 3, 1, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 3, 8, 1, 1, 9, 1, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 2, 0, 0, 0));
    vecs.push_back(v( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    // addu r4 then beq r4 (tuse 0): one stall, then M-forward in D.
    vecs.push_back(v( 1, 1, 1, 1, 4, 1, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 4, 5, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 4, 5, 0, 0, 0, 0, 0,  0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(v( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    // lw r6 then beq r6,r6: two stalls, then W-forward on both D operands.
    vecs.push_back(v( 1, 3, 1, 3, 6, 2, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 6, 6, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 6, 6, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 6, 6, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0));
    vecs.push_back(v( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    // lw r5 then sw rt=r5 (tuse 2): no stall, store data forwarded in M.
    vecs.push_back(v( 1, 3, 1, 3, 5, 2, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 1, 5, 1, 2, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    // $zero: a dst=0 writer followed by r0 readers never stalls or forwards.
    vecs.push_back(v( 1, 3, 1, 3, 0, 2, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    // Two writers of r10: the M copy wins over the W copy.
    vecs.push_back(v( 1, 3, 1, 3,10, 1, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 1, 3, 1, 3,10, 1, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(10,10, 1, 1, 0, 0, 0,  0, 2, 2, 0, 0, 0, 0));
    vecs.push_back(v( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(v( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    // mult then mflo: busy for 6 cycles, mflo held in D throughout.
    vecs.push_back(v( 1, 2, 1, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 6; k++)
      vecs.push_back(v( 0, 0, 3, 3, 8, 1, 3,  1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v( 0, 0, 3, 3, 8, 1, 3,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v( 0, 0, 3, 3, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));

    // Reset state: with reset held, every output is 0.
    reset = 1'b0;
    drive_nop();
    #12;
    check("reset_state", 32'(outs()), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rs, vecs[i].rt, vecs[i].trs, vecs[i].trt,
            vecs[i].dst, vecs[i].tnew, vecs[i].md);
      #2;
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // div: busy from the cycle it sits in E through a 10-cycle count.
    @(negedge clk);
    drive(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd0, 2'd2);
    #2;
    check("div_in_d_idle", 32'(md_busy), 32'd0);
    @(negedge clk);
    drive_nop();
    #2;
    busy_n = 0;
    guard  = 0;
    while (md_busy && guard < 30) begin
      busy_n++;
      guard++;
      @(negedge clk);
      #2;
    end
    check("div_busy_cycles", 32'(busy_n), 32'd11);

    // Reset while a div is counting (count at 7) with mflo stalled in D.
    @(negedge clk);
    drive(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd0, 2'd2);
    @(negedge clk);
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 2'd3);
    repeat (4) @(negedge clk);
    #2;
    check("pre_reset_busy_stall", 32'({stall, md_busy}), 32'b11);
    reset = 1'b0;
    #1;
    check("reset_async_outputs", 32'(outs()), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      check($sformatf("post_reset_idle%0d", k), 32'({stall, md_busy}), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
